kd_tree_controller: RTL and testbench
=====================================

Name: kd_tree_controller

Overview:
- Sequences the internal_node_tree. Loads its internal-node table, then schedules patch queries into the non-stallable traversal pipeline.
- Pairs each returned leaf_index with the tag of the query that produced it, so results come back in issue order.
- Sits between the aggregator (node words), the patch source and the downstream leaf consumer. Owns tree_fsm_enable, so node storage cannot be overwritten after the load completes.

Parameters:
PATCH_WIDTH, 55, patch width (5 x 11-bit signed components)
INTERNAL_WIDTH, 22, width of one internal-node word
ADDRESS_WIDTH, 8, leaf index width
NUM_NODES, 63, internal-node words per full load
TAG_WIDTH, 8, query tag width
MAX_INFLIGHT, 8, combined capacity of the tag FIFO and the result FIFO (power of 2)

Ports:
clk  in  1  single clock
rst  in  1  synchronous, active-high reset
start_load  in  1  pulse; request a new node-table load
node_valid  in  1  node word valid (from aggregator receiver_enq)
node_data  in  INTERNAL_WIDTH  node word
node_ready  out  1  controller accepts node word
tree_fsm_enable  out  1  to tree fsm_enable
tree_sender_enable  out  1  to tree sender_enable
tree_sender_data  out  INTERNAL_WIDTH  to tree sender_data
tree_patch_en  out  1  to tree patch_en
tree_patch_in  out  PATCH_WIDTH  to tree patch_in
tree_leaf_valid  in  1  from tree receiver_en
tree_leaf_index  in  ADDRESS_WIDTH  from tree leaf_index
query_valid  in  1  patch query valid
query_ready  out  1  query accepted this cycle when valid and ready are both high
query_patch  in  PATCH_WIDTH  patch
query_tag  in  TAG_WIDTH  caller tag
result_valid  out  1  result available
result_ready  in  1  consumer accepts result
result_leaf  out  ADDRESS_WIDTH  leaf index
result_tag  out  TAG_WIDTH  tag of the originating query
state  out  2  IDLE=0, LOAD=1, QUERY=2, DRAIN=3
nodes_loaded  out  ADDRESS_WIDTH  node words written since LOAD entry
err_orphan  out  1  sticky; tree_leaf_valid arrived while the tag FIFO was empty

Behaviour:
- Reset (synchronous, dominant over all other inputs) sets:
  - state=IDLE, nodes_loaded=0, err_orphan=0
  - both FIFOs empty
  - every tree_* output, node_ready, query_ready and result_valid = 0
- Reset mid-operation discards in-flight tags and results. Tree outputs arriving afterwards are ignored.
- IDLE:
  - start_load -> LOAD.
  - Queries are not accepted.
- LOAD:
  - tree_fsm_enable=1, node_ready=1.
  - Each node_valid cycle: register node_data onto tree_sender_data with tree_sender_enable=1 one cycle later, and increment nodes_loaded.
  - When the NUM_NODES-th word is accepted: node_ready=0 the next cycle, state -> QUERY, tree_fsm_enable=0 in the same cycle as the state change.
  - start_load during LOAD restarts the count at 0.
- QUERY:
  - query_ready = (tagfifo_count + resfifo_count < MAX_INFLIGHT). This is combinational from registered counts.
  - On accept at cycle t: tree_patch_en=1 and tree_patch_in=query_patch at t+1 (registered), and query_tag is pushed to the tag FIFO at t.
  - Back-to-back accepts produce consecutive patch_en cycles.
  - The tree never stalls. The credit check guarantees result FIFO space for every in-flight query.
- Leaf return:
  - tree_leaf_valid pops the tag FIFO and pushes {tag, tree_leaf_index} into the result FIFO.
  - result_valid rises at the next cycle.
  - Orphan case (leaf with empty tag FIFO): drop it and set err_orphan.
- Result FIFO is show-ahead. Pop on result_valid && result_ready.
- Push and pop in the same cycle keep the count unchanged. Issue and return in the same cycle are legal.
- start_load in QUERY -> DRAIN:
  - query_ready=0.
  - Remain in DRAIN until the tag FIFO is empty, then -> LOAD with nodes_loaded cleared.
  - The result FIFO does not have to be empty before reloading.
- Width rules:
  - nodes_loaded saturates at NUM_NODES.
  - FIFO counts are $clog2(MAX_INFLIGHT)+1 bits; pointers wrap modulo MAX_INFLIGHT.

Decomposition:
- Package kd_ctrl_pkg holds:
  - state enum (IDLE/LOAD/QUERY/DRAIN)
  - result struct {tag, leaf}
  - PATCH_WIDTH / INTERNAL_WIDTH / ADDRESS_WIDTH defaults
- Sub-module ctrl_sync_fifo (parameterised width/depth, show-ahead, count output) is instantiated twice: tag FIFO and result FIFO.

Test Plan:
- Load: start_load, then 63 node words, node_valid gapped randomly -> exactly 63 tree_sender_enable pulses, data in order. node_ready=0 and state=QUERY after the 63rd. tree_fsm_enable=0 from then on.
- Single query: patch [251,-26,-1,-88,79], tag 3 -> tree_patch_en exactly 1 cycle after accept. Result {tag 3, leaf 59}.
- Pipelined: patches [-72,-213,201,45,235], [-245,-199,45,58,177], [-50,-64,-298,245,-141] on consecutive cycles, tags 0,1,2 -> results (0,22), (1,5), (2,24) in order.
- Backpressure: result_ready=0, 10 queries offered -> exactly 8 accepted, then query_ready=0. Raising result_ready drains all 10 results in tag order with no loss.
- Reload: start_load with 4 queries in flight -> DRAIN, query_ready=0. LOAD is entered only after the 4th leaf returns. All 4 results are delivered.
- Faults: tree_leaf_valid forced with empty tag FIFO -> err_orphan=1, no result. rst mid-LOAD at word 30 -> state=IDLE, nodes_loaded=0, err_orphan=0 next cycle.

Source files
------------

// File: rtl/kd_ctrl_pkg.sv
// kd_ctrl_pkg: shared types and default widths for the kd-tree controller.
//   - kd_state_e  : controller FSM encoding, visible on the state port
//   - kd_result_t : {tag, leaf} pair delivered to the leaf consumer
//   - KD_*        : default widths for the controller parameters
package kd_ctrl_pkg;

    localparam int KD_PATCH_W    = 55;   // 5 x 11-bit signed components
    localparam int KD_INTERNAL_W = 22;
    localparam int KD_ADDR_W     = 8;
    localparam int KD_TAG_W      = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_QUERY = 2'd2,
        ST_DRAIN = 2'd3
    } kd_state_e;

    typedef struct packed {
        logic [KD_TAG_W-1:0]  tag;
        logic [KD_ADDR_W-1:0] leaf;
    } kd_result_t;

endpackage

// File: rtl/ctrl_sync_fifo.sv
// ctrl_sync_fifo: single-clock show-ahead FIFO with occupancy count.
//   clk, rst      : clock, synchronous active-high reset (empties the FIFO)
//   push_i/data_i : write request and data (ignored when full without pop)
//   pop_i         : read request (ignored when empty)
//   data_o        : head entry, valid whenever empty_o is low
//   empty_o       : no entries
//   count_o       : number of entries, 0..DEPTH
// DEPTH must be a power of two (>= 2) so the pointers wrap naturally.
module ctrl_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             empty_o,
    output logic [CW-1:0]    count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             full, do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign full    = (count_q == CW'(DEPTH));
    assign count_o = count_q;
    assign data_o  = mem_q[rd_ptr_q];

    assign do_pop  = pop_i && !empty_o;
    // A pop frees the head slot this cycle, so a full FIFO may still accept.
    assign do_push = push_i && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    // Storage needs no reset: entries are only read once counted.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/kd_tree_controller.sv
// kd_tree_controller: loads the internal-node table of the kd-tree, then
// issues patch queries into the non-stallable traversal pipeline and pairs
// each returned leaf index with the tag of the query that produced it.
//   clk, rst                 : clock, synchronous active-high reset
//   start_load               : request a (re)load of the node table
//   node_valid/data/ready    : node words from the aggregator
//   tree_fsm_enable          : high only while loading node storage
//   tree_sender_enable/data  : registered node word towards the tree
//   tree_patch_en/in         : registered query patch towards the tree
//   tree_leaf_valid/index    : leaf returned by the tree (in issue order)
//   query_valid/ready/patch/tag : query source handshake
//   result_valid/ready/leaf/tag : result consumer handshake
//   state, nodes_loaded      : status
//   err_orphan               : sticky, leaf returned with no tag outstanding
module kd_tree_controller
    import kd_ctrl_pkg::*;
#(
    parameter int PATCH_WIDTH    = KD_PATCH_W,
    parameter int INTERNAL_WIDTH = KD_INTERNAL_W,
    parameter int ADDRESS_WIDTH  = KD_ADDR_W,
    parameter int NUM_NODES      = 63,
    parameter int TAG_WIDTH      = KD_TAG_W,
    parameter int MAX_INFLIGHT   = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start_load,
    input  logic                      node_valid,
    input  logic [INTERNAL_WIDTH-1:0] node_data,
    output logic                      node_ready,
    output logic                      tree_fsm_enable,
    output logic                      tree_sender_enable,
    output logic [INTERNAL_WIDTH-1:0] tree_sender_data,
    output logic                      tree_patch_en,
    output logic [PATCH_WIDTH-1:0]    tree_patch_in,
    input  logic                      tree_leaf_valid,
    input  logic [ADDRESS_WIDTH-1:0]  tree_leaf_index,
    input  logic                      query_valid,
    output logic                      query_ready,
    input  logic [PATCH_WIDTH-1:0]    query_patch,
    input  logic [TAG_WIDTH-1:0]      query_tag,
    output logic                      result_valid,
    input  logic                      result_ready,
    output logic [ADDRESS_WIDTH-1:0]  result_leaf,
    output logic [TAG_WIDTH-1:0]      result_tag,
    output logic [1:0]                state,
    output logic [ADDRESS_WIDTH-1:0]  nodes_loaded,
    output logic                      err_orphan
);

    localparam int CW = $clog2(MAX_INFLIGHT) + 1;
    localparam int RW = TAG_WIDTH + ADDRESS_WIDTH;
    localparam logic [CW:0] MAX_CREDIT = (CW+1)'(MAX_INFLIGHT);

    kd_state_e                 state_q, state_d;
    logic [ADDRESS_WIDTH-1:0]  nodes_q, nodes_d;
    logic                      sender_en_q;
    logic [INTERNAL_WIDTH-1:0] sender_data_q;
    logic                      patch_en_q;
    logic [PATCH_WIDTH-1:0]    patch_in_q;
    logic                      err_orphan_q;

    logic                      node_acc, query_acc, leaf_ok, leaf_orphan;
    logic                      tag_empty, res_empty;
    logic [CW-1:0]             tag_cnt, res_cnt;
    logic [CW:0]               inflight;
    logic [TAG_WIDTH-1:0]      tag_head;
    logic [RW-1:0]             res_head;

    // Credit covers both FIFOs: each query in flight either holds a tag or,
    // once its leaf returns, a result slot, so the tree can never overrun.
    assign inflight    = {1'b0, tag_cnt} + {1'b0, res_cnt};
    assign node_ready  = (state_q == ST_LOAD);
    assign query_ready = (state_q == ST_QUERY) && (inflight < MAX_CREDIT);
    assign node_acc    = node_valid && node_ready;
    assign query_acc   = query_valid && query_ready;
    // A non-empty tag FIFO can only exist in QUERY/DRAIN. Stray leaves in
    // IDLE/LOAD (e.g. pipeline leftovers after a reset) are silently ignored.
    assign leaf_ok     = tree_leaf_valid && !tag_empty;
    assign leaf_orphan = tree_leaf_valid && tag_empty &&
                         (state_q == ST_QUERY || state_q == ST_DRAIN);

    always_comb begin
        state_d = state_q;
        nodes_d = nodes_q;
        case (state_q)
            ST_IDLE: begin
                if (start_load) begin
                    state_d = ST_LOAD;
                    nodes_d = '0;
                end
            end
            ST_LOAD: begin
                if (start_load) begin
                    nodes_d = '0;
                end else if (node_acc) begin
                    if (nodes_q != ADDRESS_WIDTH'(NUM_NODES))
                        nodes_d = nodes_q + ADDRESS_WIDTH'(1);
                    if (nodes_q == ADDRESS_WIDTH'(NUM_NODES - 1))
                        state_d = ST_QUERY;
                end
            end
            ST_QUERY: begin
                if (start_load) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                // Results may still be queued; only outstanding tags block.
                if (tag_empty) begin
                    state_d = ST_LOAD;
                    nodes_d = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            nodes_q       <= '0;
            sender_en_q   <= 1'b0;
            sender_data_q <= '0;
            patch_en_q    <= 1'b0;
            patch_in_q    <= '0;
            err_orphan_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            nodes_q     <= nodes_d;
            sender_en_q <= node_acc;
            if (node_acc)  sender_data_q <= node_data;
            patch_en_q  <= query_acc;
            if (query_acc) patch_in_q <= query_patch;
            if (leaf_orphan) err_orphan_q <= 1'b1;
        end
    end

    ctrl_sync_fifo #(.WIDTH(TAG_WIDTH), .DEPTH(MAX_INFLIGHT)) u_tag_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (query_acc),
        .data_i  (query_tag),
        .pop_i   (leaf_ok),
        .data_o  (tag_head),
        .empty_o (tag_empty),
        .count_o (tag_cnt)
    );

    ctrl_sync_fifo #(.WIDTH(RW), .DEPTH(MAX_INFLIGHT)) u_res_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (leaf_ok),
        .data_i  ({tag_head, tree_leaf_index}),
        .pop_i   (result_valid && result_ready),
        .data_o  (res_head),
        .empty_o (res_empty),
        .count_o (res_cnt)
    );

    assign tree_fsm_enable    = (state_q == ST_LOAD);
    assign tree_sender_enable = sender_en_q;
    assign tree_sender_data   = sender_data_q;
    assign tree_patch_en      = patch_en_q;
    assign tree_patch_in      = patch_in_q;
    assign result_valid       = !res_empty;
    assign result_leaf        = res_head[ADDRESS_WIDTH-1:0];
    assign result_tag         = res_head[RW-1:ADDRESS_WIDTH];
    assign state              = state_q;
    assign nodes_loaded       = nodes_q;
    assign err_orphan         = err_orphan_q;

endmodule

// File: tb/tb_kd_tree_controller.sv
// Directed bench for kd_tree_controller. The tree is modelled by a fixed
// latency pipeline that maps known patches to hand-chosen leaf indices.
module tb_kd_tree_controller;
    import kd_ctrl_pkg::*;

    localparam int LAT = 4;

    logic        clk, rst, start_load;
    logic        node_valid, node_ready;
    logic [21:0] node_data;
    logic        tree_fsm_enable, tree_sender_enable, tree_patch_en;
    logic [21:0] tree_sender_data;
    logic [54:0] tree_patch_in, query_patch;
    logic        tree_leaf_valid;
    logic [7:0]  tree_leaf_index;
    logic        query_valid, query_ready;
    logic [7:0]  query_tag;
    logic        result_valid, result_ready;
    logic [7:0]  result_leaf, result_tag;
    logic [1:0]  state;
    logic [7:0]  nodes_loaded;
    logic        err_orphan;

    kd_tree_controller dut (
        .clk(clk), .rst(rst), .start_load(start_load),
        .node_valid(node_valid), .node_data(node_data), .node_ready(node_ready),
        .tree_fsm_enable(tree_fsm_enable),
        .tree_sender_enable(tree_sender_enable), .tree_sender_data(tree_sender_data),
        .tree_patch_en(tree_patch_en), .tree_patch_in(tree_patch_in),
        .tree_leaf_valid(tree_leaf_valid), .tree_leaf_index(tree_leaf_index),
        .query_valid(query_valid), .query_ready(query_ready),
        .query_patch(query_patch), .query_tag(query_tag),
        .result_valid(result_valid), .result_ready(result_ready),
        .result_leaf(result_leaf), .result_tag(result_tag),
        .state(state), .nodes_loaded(nodes_loaded), .err_orphan(err_orphan)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_chk = 0, n_fail = 0;
    int snd_cnt = 0, got_cnt = 0, leaves_ret = 0;
    logic orphan_req = 1'b0;
    logic [21:0] snd_q[$];
    kd_result_t  exp_q[$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [54:0] mkp(input int a, input int b, input int c, input int d, input int e);
        return {11'(e), 11'(d), 11'(c), 11'(b), 11'(a)};
    endfunction

    // Stand-in for the traversal result of each patch.
    function automatic logic [7:0] leaf_fn(input logic [54:0] p);
        if (p == mkp(251, -26, -1, -88, 79))     return 8'd59;
        if (p == mkp(-72, -213, 201, 45, 235))   return 8'd22;
        if (p == mkp(-245, -199, 45, 58, 177))   return 8'd5;
        if (p == mkp(-50, -64, -298, 245, -141)) return 8'd24;
        return p[7:0] ^ 8'hA5;
    endfunction

    function automatic logic [54:0] tpat(input int t);
        return mkp(t * 5, -t * 3, t, -7, t * 2 + 1);
    endfunction

    // Tree model: fixed-latency, never stalls.
    logic       dv[LAT];
    logic [7:0] dl[LAT];
    initial begin
        for (int i = 0; i < LAT; i++) begin dv[i] = 1'b0; dl[i] = '0; end
        tree_leaf_valid = 1'b0;
        tree_leaf_index = '0;
        forever begin
            @(negedge clk);
            tree_leaf_valid = dv[LAT-1] | orphan_req;
            tree_leaf_index = dl[LAT-1];
            if (dv[LAT-1]) leaves_ret++;
            for (int i = LAT - 1; i > 0; i--) begin dv[i] = dv[i-1]; dl[i] = dl[i-1]; end
            dv[0] = tree_patch_en && !rst;
            dl[0] = leaf_fn(tree_patch_in);
        end
    end

    // Result collector.
    initial begin
        kd_result_t e;
        forever begin
            @(negedge clk);
            if (result_valid && result_ready) begin
                got_cnt++;
                if (exp_q.size() == 0) chk("res_extra", 1, 0);
                else begin
                    e = exp_q.pop_front();
                    chk("res_tag", result_tag, e.tag);
                    chk("res_leaf", result_leaf, e.leaf);
                end
            end
        end
    end

    // Node-word monitor.
    initial begin
        forever begin
            @(negedge clk);
            if (tree_sender_enable) begin
                snd_cnt++;
                if (snd_q.size() == 0) chk("snd_extra", 1, 0);
                else chk("snd_data", tree_sender_data, snd_q.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_nodes(input int n, input bit gapped, input int base);
        for (int i = 0; i < n; i++) begin
            if (gapped) begin
                node_valid = 1'b0;
                repeat ($urandom_range(0, 2)) tick();
            end
            node_valid = 1'b1;
            node_data  = 22'(base + i * 37 + 5);
            snd_q.push_back(node_data);
            tick();
        end
        node_valid = 1'b0;
    endtask

    task automatic wait_res(input int target, input int budget);
        int k = 0;
        while (got_cnt < target && k < budget) begin tick(); k++; end
        chk("res_count", got_cnt >= target, 1);
    endtask

    task automatic issue(input logic [54:0] p, input logic [7:0] t);
        kd_result_t e;
        query_valid = 1'b1;
        query_patch = p;
        query_tag   = t;
        chk("q_ready", query_ready, 1);
        e.tag = t;
        e.leaf = leaf_fn(p);
        exp_q.push_back(e);
        tick();
        chk("patch_en", tree_patch_en, 1);
        chk("patch_in", tree_patch_in, p);
    endtask

    initial begin
        int acc, tagn, k, lbase, gbase;
        kd_result_t e;
        rst = 1'b1; start_load = 0; node_valid = 0; node_data = '0;
        query_valid = 0; query_patch = '0; query_tag = '0; result_ready = 1'b1;
        repeat (3) tick();
        @(negedge clk);
        chk("rst_state", state, 0);
        chk("rst_nodes", nodes_loaded, 0);
        chk("rst_orphan", err_orphan, 0);
        chk("rst_node_ready", node_ready, 0);
        chk("rst_query_ready", query_ready, 0);
        chk("rst_result_valid", result_valid, 0);
        chk("rst_tree_out", {tree_fsm_enable, tree_sender_enable, tree_patch_en}, 0);
        tick();
        rst = 1'b0;

        // IDLE ignores queries.
        query_valid = 1'b1;
        tick();
        chk("idle_q_ready", query_ready, 0);
        query_valid = 1'b0;

        // Gapped load of 63 words.
        start_load = 1'b1; tick(); start_load = 1'b0;
        chk("load_state", state, 1);
        chk("load_fsm_en", tree_fsm_enable, 1);
        chk("load_node_ready", node_ready, 1);
        snd_cnt = 0;
        load_nodes(63, 1'b1, 0);
        @(negedge clk);
        chk("post_load_state", state, 2);
        chk("post_load_node_ready", node_ready, 0);
        chk("post_load_fsm_en", tree_fsm_enable, 0);
        chk("post_load_nodes", nodes_loaded, 63);
        tick(); tick();
        chk("snd_pulses", snd_cnt, 63);
        chk("fsm_en_stays_low", tree_fsm_enable, 0);

        // Single query.
        issue(mkp(251, -26, -1, -88, 79), 8'd3);
        query_valid = 1'b0;
        tick();
        chk("patch_en_single", tree_patch_en, 0);
        wait_res(1, 30);

        // Pipelined.
        issue(mkp(-72, -213, 201, 45, 235), 8'd0);
        issue(mkp(-245, -199, 45, 58, 177), 8'd1);
        issue(mkp(-50, -64, -298, 245, -141), 8'd2);
        query_valid = 1'b0;
        wait_res(4, 30);

        // Backpressure: 10 offered, 8 fit.
        result_ready = 1'b0;
        acc = 0; tagn = 10; gbase = got_cnt;
        for (int c = 0; c < 20; c++) begin
            query_valid = (acc < 10);
            query_patch = tpat(tagn);
            query_tag   = 8'(tagn);
            if (query_ready && acc < 10) begin
                e.tag = 8'(tagn); e.leaf = leaf_fn(tpat(tagn));
                exp_q.push_back(e);
                acc++; tagn++;
            end
            tick();
        end
        chk("bp_accepted", acc, 8);
        chk("bp_q_ready", query_ready, 0);
        chk("bp_no_result_out", got_cnt, gbase);
        result_ready = 1'b1;
        k = 0;
        while (acc < 10 && k < 40) begin
            query_valid = 1'b1;
            query_patch = tpat(tagn);
            query_tag   = 8'(tagn);
            if (query_ready) begin
                e.tag = 8'(tagn); e.leaf = leaf_fn(tpat(tagn));
                exp_q.push_back(e);
                acc++; tagn++;
            end
            tick(); k++;
        end
        query_valid = 1'b0;
        chk("bp_total", acc, 10);
        wait_res(gbase + 10, 60);

        // Reload with 4 queries in flight.
        lbase = leaves_ret; gbase = got_cnt;
        for (int i = 0; i < 4; i++) issue(tpat(40 + i), 8'(40 + i));
        query_valid = 1'b0;
        start_load = 1'b1; tick(); start_load = 1'b0;
        chk("drain_state", state, 3);
        chk("drain_q_ready", query_ready, 0);
        k = 0;
        while (state == 2'd3 && k < 50) begin tick(); k++; end
        chk("drain_exit_state", state, 1);
        chk("drain_leaves_back", leaves_ret - lbase, 4);
        chk("drain_nodes_clr", nodes_loaded, 0);
        wait_res(gbase + 4, 30);
        snd_cnt = 0;
        load_nodes(63, 1'b0, 1000);
        @(negedge clk);
        chk("reload_state", state, 2);
        tick(); tick();
        chk("reload_snd_pulses", snd_cnt, 63);

        // Orphan leaf.
        gbase = got_cnt;
        orphan_req = 1'b1; tick(); orphan_req = 1'b0; tick();
        @(negedge clk);
        chk("orphan_flag", err_orphan, 1);
        chk("orphan_no_result", result_valid, 0);
        chk("orphan_no_count", got_cnt, gbase);

        // Reset mid-LOAD at word 30.
        start_load = 1'b1; tick(); start_load = 1'b0;
        k = 0;
        while (state != 2'd1 && k < 10) begin tick(); k++; end
        load_nodes(30, 1'b0, 2000);
        @(negedge clk);
        chk("mid_nodes", nodes_loaded, 30);
        tick();
        rst = 1'b1; tick(); rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_state", state, 0);
        chk("mid_rst_nodes", nodes_loaded, 0);
        chk("mid_rst_orphan", err_orphan, 0);
        chk("mid_rst_fsm_en", tree_fsm_enable, 0);
        tick(); tick();
        chk("snd_q_drained", snd_q.size(), 0);
        chk("exp_q_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
